// File: rtl/imm_sequencer.sv
// imm_sequencer: multi-cycle immediate-operand controller for the write path.
// Turns 2-bit decoder immediate fields into one WIDTH-bit operand, either by
// zero/sign-extending a single field or by accumulating fields MSB-first.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   decoder command handshake
//   in_cmd              00=ZX, 01=SX, 10=EXT (accumulate), 11=EXT_LAST (accumulate and emit)
//   in_field            immediate field
//   abort               synchronous flush, highest priority
//   out_valid/out_ready operand handshake towards the datapath
//   out_data            completed operand
//   out_chunks          number of fields that formed out_data
//   err                 sticky protocol error (cleared by abort or reset only)
module imm_sequencer #(
   parameter int WIDTH = 8,
   parameter int FIELD = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_cmd,
   input  logic [FIELD-1:0] in_field,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [3:0]       out_chunks,
   output logic             err
);
   localparam int CHUNKS = WIDTH / FIELD;
   localparam int CW = $clog2(CHUNKS + 1);
   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUT} state_t;
   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_acc;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] w_shift, w_ext;
   logic [CW-1:0]    w_count_inc;
   logic             w_fire, w_single, w_sat;
   assign w_fire      = in_valid && in_ready;
   assign w_single    = !in_cmd[1];
   assign w_sat       = r_count == CW'(CHUNKS);
   // count saturates at CHUNKS; further fields push the oldest off the MSB end
   assign w_count_inc = w_sat ? r_count : r_count + 1'b1;
   assign w_shift     = {r_acc[WIDTH-FIELD-1:0], in_field};
   assign w_ext       = in_cmd[0] ? {{(WIDTH-FIELD){in_field[FIELD-1]}}, in_field}
                                  : {{(WIDTH-FIELD){1'b0}}, in_field};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      if (abort)                  w_next = S_IDLE;
      else if (r_state == S_OUT)  w_next = out_ready ? S_IDLE : S_OUT;
      else if (w_fire)            w_next = (in_cmd == 2'b10) ? S_ACCUM : S_OUT;
   end
   always_comb begin
      in_ready  = (r_state != S_OUT) && !abort;
      out_valid = r_state == S_OUT;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc      <= '0;
         r_count    <= '0;
         out_data   <= '0;
         out_chunks <= '0;
         err        <= 1'b0;
      end else if (abort) begin
         r_acc      <= '0;
         r_count    <= '0;
         out_data   <= '0;
         out_chunks <= '0;
         err        <= 1'b0;
      end else if (w_fire) begin
         if (w_single) begin
            // a single-field command inside an accumulation drops the partial operand
            out_data   <= w_ext;
            out_chunks <= 4'd1;
            r_acc      <= '0;
            r_count    <= '0;
            if (r_state == S_ACCUM) err <= 1'b1;
         end else begin
            if (w_sat) err <= 1'b1;
            if (in_cmd[0]) begin
               out_data   <= w_shift;
               out_chunks <= 4'(w_count_inc);
               r_acc      <= '0;
               r_count    <= '0;
            end else begin
               r_acc      <= w_shift;
               r_count    <= w_count_inc;
            end
         end
      end
   end
endmodule
